// File: rtl/alu_pkg.sv
// Shared opcode map, default sizing and FSM state type for the ALU sequencer.
package alu_pkg;

  localparam int OPCODE_W_DEF  = 4;
  localparam int NUM_OPS_DEF   = 14;
  localparam int LEGAL_OPS_DEF = 13;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_DIV  = 3;
  localparam int OP_AND  = 4;
  localparam int OP_OR   = 5;
  localparam int OP_NAND = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_XNOR = 8;
  localparam int OP_NOT  = 9;
  localparam int OP_CMP  = 10;
  localparam int OP_LSH  = 11;
  localparam int OP_RSH  = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Opcode handshake plus the sequencer's status/control outputs.
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int NUM_OPS  = NUM_OPS_DEF
);

  logic                flush;
  logic                op_valid;
  logic                op_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [NUM_OPS-1:0]  control_signals;
  logic                busy;
  logic                done;
  logic                illegal;
  logic [15:0]         op_count;

  modport master (
    output flush, op_valid, opcode,
    input  op_ready, control_signals, busy, done, illegal, op_count
  );

  modport slave (
    input  flush, op_valid, opcode,
    output op_ready, control_signals, busy, done, illegal, op_count
  );

endinterface

// File: rtl/op_onehot_dec.sv
// Opcode to one-hot control decode; illegal opcodes decode to all-zero.
module op_onehot_dec #(
  parameter int OPCODE_W  = 4,
  parameter int NUM_OPS   = 14,
  parameter int LEGAL_OPS = 13
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [NUM_OPS-1:0]  onehot
);

  // NOTE: assigning a default before any conditional write keeps this purely combinational (no latch).
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if ((i < LEGAL_OPS) && (int'(opcode) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Two-state opcode sequencer: accepts one opcode, holds its one-hot control
// for the opcode's latency, pulses done on the last cycle and counts completions.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int OPCODE_W   = OPCODE_W_DEF,
  parameter int NUM_OPS    = NUM_OPS_DEF,
  parameter int LEGAL_OPS  = LEGAL_OPS_DEF,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input logic            clk,
  input logic            rst_n,
  alu_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]    MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [OPCODE_W-1:0] MUL_CODE = OPCODE_W'(OP_MUL);
  localparam logic [OPCODE_W-1:0] DIV_CODE = OPCODE_W'(OP_DIV);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_OPS-1:0] ctrl, ctrl_nxt;
  logic               illegal_q, illegal_nxt;
  logic [15:0]        count_q, count_nxt;

  logic [NUM_OPS-1:0] dec_onehot;
  logic               legal;
  logic [CNT_W-1:0]   op_last;
  logic               last_cycle;
  logic               ready;
  logic               handshake;

  op_onehot_dec #(
    .OPCODE_W  (OPCODE_W),
    .NUM_OPS   (NUM_OPS),
    .LEGAL_OPS (LEGAL_OPS)
  ) u_dec (
    .opcode (bus.opcode),
    .onehot (dec_onehot)
  );

  assign legal      = int'(bus.opcode) < LEGAL_OPS;
  assign last_cycle = (state == ST_EXEC) && (cnt == '0);
  assign ready      = ((state == ST_IDLE) || last_cycle) && !bus.flush;
  assign handshake  = bus.op_valid && ready;

  always_comb begin
    op_last = '0;
    if (bus.opcode == MUL_CODE)      op_last = MUL_LAST;
    else if (bus.opcode == DIV_CODE) op_last = DIV_LAST;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ctrl_nxt    = ctrl;
    illegal_nxt = 1'b0;
    count_nxt   = count_q;

    if (bus.flush) begin
      // Abort wins over completion and acceptance alike.
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      ctrl_nxt  = '0;
    end else begin
      if (state == ST_EXEC) begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          count_nxt = count_q + 16'd1;
          state_nxt = ST_IDLE;
          ctrl_nxt  = '0;
        end
      end
      if (handshake) begin
        if (legal) begin
          state_nxt = ST_EXEC;
          cnt_nxt   = op_last;
          ctrl_nxt  = dec_onehot;
        end else begin
          illegal_nxt = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ctrl      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ctrl      <= ctrl_nxt;
      illegal_q <= illegal_nxt;
      count_q   <= count_nxt;
    end
  end

  assign bus.op_ready        = ready;
  assign bus.control_signals = ctrl;
  assign bus.busy            = (state == ST_EXEC);
  assign bus.done            = last_cycle && !bus.flush;
  assign bus.illegal         = illegal_q;
  assign bus.op_count        = count_q;

endmodule
